// File: rtl/mem_stage_access_ctrl_if.sv
// rtl/mem_stage_access_ctrl_if.sv - data-memory req/ack bus between the memory-stage controller and the data memory
`timescale 1ns/1ps

interface mem_stage_access_ctrl_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    // controller side
    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    // memory side
    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_stage_access_ctrl.sv
// rtl/mem_stage_access_ctrl.sv - memory-stage data-access controller, optional MEM_TIMEOUT_EN abort on missing ack
`timescale 1ns/1ps

module mem_stage_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      MemRead_M,
    input  logic                      MemWrite_M,
    input  logic [3:0]                ByteControl_M,
    input  logic                      LoadSigned_M,
    input  logic [31:0]               Addr_M,
    input  logic [31:0]               WriteData_M,
    mem_stage_access_ctrl_if.master   bus,
    output logic                      stall_M,
    output logic [31:0]               ReadData_M,
    output logic                      access_done,
    output logic                      bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      r_state;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_access_done;
    logic        w_access;
    logic        w_unused;

    // the counter width must be able to reach the last waiting cycle
    if ((64'd1 << TO_CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cfg_err
        $error("TO_CNT_W too narrow for TIMEOUT_CYCLES");
    end

`ifdef MEM_TIMEOUT_EN
    logic [TO_CNT_W-1:0] r_to_cnt;
    logic                r_bus_err;
    assign bus_err = r_bus_err;
`else
    assign bus_err = 1'b0;
`endif

    // byte address bits only matter for lane selection, which comes from the enables
    assign w_unused = &{1'b0, Addr_M[1:0]};

    assign w_access = (MemRead_M | MemWrite_M) & (ByteControl_M != 4'b0000);

    // replicate sub-word store data across every lane it could land in
    function automatic logic [31:0] f_steer(input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] r;
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: r = {4{wd[7:0]}};
            4'b0011, 4'b1100:                   r = {2{wd[15:0]}};
            default:                            r = wd;
        endcase
        return r;
    endfunction

    // move the selected lane down to bit 0 and extend it
    function automatic logic [31:0] f_align(input logic [3:0] be, input logic [31:0] d, input logic sgn);
        logic [31:0] r;
        case (be)
            4'b0001: r = {{24{sgn & d[7]}},  d[7:0]};
            4'b0010: r = {{24{sgn & d[15]}}, d[15:8]};
            4'b0100: r = {{24{sgn & d[23]}}, d[23:16]};
            4'b1000: r = {{24{sgn & d[31]}}, d[31:24]};
            4'b0011: r = {{16{sgn & d[15]}}, d[15:0]};
            4'b1100: r = {{16{sgn & d[31]}}, d[31:16]};
            default: r = d;
        endcase
        return r;
    endfunction

    // access FSM: launch in IDLE, wait for ack in BUSY, retire for one cycle in DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_req         <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= 32'h0;
            r_be          <= 4'h0;
            r_wdata       <= 32'h0;
            r_rdata       <= 32'h0;
            r_access_done <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_bus_err     <= 1'b0;
`endif
        end else begin
            r_access_done <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_bus_err     <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_req   <= 1'b1;
                        r_we    <= MemWrite_M;
                        r_addr  <= {Addr_M[31:2], 2'b00};
                        r_be    <= ByteControl_M;
                        r_wdata <= f_steer(ByteControl_M, WriteData_M);
                        r_state <= S_BUSY;
`ifdef MEM_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end
                end
                S_BUSY: begin
                    if (bus.dmem_ack) begin
                        r_req         <= 1'b0;
                        r_access_done <= 1'b1;
                        r_state       <= S_DONE;
                        if (!r_we) begin
                            r_rdata <= f_align(r_be, bus.dmem_rdata, LoadSigned_M);
                        end
`ifdef MEM_TIMEOUT_EN
                    end else if (r_to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_req         <= 1'b0;
                        r_access_done <= 1'b1;
                        r_bus_err     <= 1'b1;
                        r_state       <= S_DONE;
                        if (!r_we) begin
                            r_rdata <= 32'h0;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // hold the pipeline from the cycle the access is seen until it retires
    always_comb begin
        stall_M = 1'b0;
        case (r_state)
            S_IDLE:  stall_M = w_access;
            S_BUSY:  stall_M = 1'b1;
            default: stall_M = 1'b0;
        endcase
    end

    assign bus.dmem_req   = r_req;
    assign bus.dmem_we    = r_we;
    assign bus.dmem_addr  = r_addr;
    assign bus.dmem_be    = r_be;
    assign bus.dmem_wdata = r_wdata;
    assign ReadData_M     = r_rdata;
    assign access_done    = r_access_done;

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// tb/tb_mem_stage_access_ctrl.sv - directed bench with a transaction-level expectation model for mem_stage_access_ctrl
`timescale 1ns/1ps

module tb_mem_stage_access_ctrl;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead_M, MemWrite_M, LoadSigned_M;
    logic [3:0]  ByteControl_M;
    logic [31:0] Addr_M, WriteData_M;
    logic        stall_M, access_done, bus_err;
    logic [31:0] ReadData_M;

    mem_stage_access_ctrl_if bus();

    mem_stage_access_ctrl #(.TIMEOUT_CYCLES(TO), .TO_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
        .ByteControl_M(ByteControl_M), .LoadSigned_M(LoadSigned_M),
        .Addr_M(Addr_M), .WriteData_M(WriteData_M),
        .bus(bus),
        .stall_M(stall_M), .ReadData_M(ReadData_M),
        .access_done(access_done), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic check_en = 1'b0;

    logic        exp_stall, exp_req, exp_we, exp_done, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_rd;
    logic [3:0]  exp_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // expected store data: replicate a byte or half across the word
    function automatic logic [31:0] model_steer(input logic [3:0] be, input logic [31:0] wd);
        if ($countones(be) == 1) return {4{wd[7:0]}};
        if (be == 4'b0011 || be == 4'b1100) return {2{wd[15:0]}};
        return wd;
    endfunction

    // expected load data: shift the enabled lane down, mask, then extend
    function automatic logic [31:0] model_align(input logic [3:0] be, input logic [31:0] rd, input logic sgn);
        logic [31:0] v;
        int k;
        if ($countones(be) == 1) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (be[i]) k = i;
            v = (rd >> (8 * k)) & 32'h0000_00FF;
            if (sgn && v[7]) v = v | 32'hFFFF_FF00;
            return v;
        end
        if (be == 4'b0011 || be == 4'b1100) begin
            k = be[2] ? 16 : 0;
            v = (rd >> k) & 32'h0000_FFFF;
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
            return v;
        end
        return rd;
    endfunction

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("stall_M",     {31'b0, stall_M},        {31'b0, exp_stall});
            chk("dmem_req",    {31'b0, bus.dmem_req},   {31'b0, exp_req});
            chk("dmem_we",     {31'b0, bus.dmem_we},    {31'b0, exp_we});
            chk("dmem_addr",   bus.dmem_addr,           exp_addr);
            chk("dmem_be",     {28'b0, bus.dmem_be},    {28'b0, exp_be});
            chk("dmem_wdata",  bus.dmem_wdata,          exp_wdata);
            chk("ReadData_M",  ReadData_M,              exp_rd);
            chk("access_done", {31'b0, access_done},    {31'b0, exp_done});
            chk("bus_err",     {31'b0, bus_err},        {31'b0, exp_err});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one memory-stage instruction; ack arrives in BUSY cycle index wait_n
    task automatic run_access(input logic rd, input logic wr, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wd, input logic sgn,
                              input logic [31:0] rdata, input int wait_n, output int stalls);
        logic acc;
        logic abort;
        int   nbusy;
        stalls = 0;
        step();
        MemRead_M = rd; MemWrite_M = wr; ByteControl_M = be;
        Addr_M = addr; WriteData_M = wd; LoadSigned_M = sgn;
        bus.dmem_ack = 1'b0;
        acc = (rd | wr) && (be != 4'b0000);
        exp_stall = acc; exp_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        @(negedge clk);
        if (stall_M) stalls++;
        if (!acc) return;
        abort = 1'b0;
        nbusy = wait_n + 1;
`ifdef MEM_TIMEOUT_EN
        if (wait_n >= TO) begin
            abort = 1'b1;
            nbusy = TO;
        end
`endif
        for (int b = 0; b < nbusy; b++) begin
            step();
            exp_req = 1'b1; exp_stall = 1'b1; exp_done = 1'b0;
            exp_we = wr; exp_addr = {addr[31:2], 2'b00}; exp_be = be;
            exp_wdata = model_steer(be, wd);
            bus.dmem_ack   = (!abort && b == wait_n);
            bus.dmem_rdata = (b == wait_n) ? rdata : 32'hDEAD_BEEF;
            @(negedge clk);
            if (stall_M) stalls++;
        end
        step();
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 32'h5A5A_5A5A;
        exp_req = 1'b0; exp_stall = 1'b0; exp_done = 1'b1; exp_err = abort;
        if (!wr) exp_rd = abort ? 32'h0 : model_align(be, rdata, sgn);
        @(negedge clk);
        if (stall_M) stalls++;
    endtask

    task automatic idle_cycle(input logic ack);
        step();
        MemRead_M = 1'b0; MemWrite_M = 1'b0;
        bus.dmem_ack = ack;
        bus.dmem_rdata = 32'h1357_9BDF;
        exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        @(negedge clk);
    endtask

    int st;

    initial begin
        MemRead_M = 0; MemWrite_M = 0; ByteControl_M = 0; LoadSigned_M = 0;
        Addr_M = 0; WriteData_M = 0;
        bus.dmem_ack = 0; bus.dmem_rdata = 0;
        exp_stall = 0; exp_req = 0; exp_we = 0; exp_done = 0; exp_err = 0;
        exp_addr = 0; exp_wdata = 0; exp_rd = 0; exp_be = 0;

        step();
        check_en = 1'b1;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rd", ReadData_M, 32'h0);
        chk("reset_req", {31'b0, bus.dmem_req}, 32'h0);

        // byte store, ack in first BUSY cycle
        run_access(1'b0, 1'b1, 4'b1000, 32'h0000_0103, 32'h0000_00AB, 1'b0, 32'h0, 0, st);
        chk("st_stall_cnt", st, 32'd2);
        chk("st_wdata", bus.dmem_wdata, 32'hABAB_ABAB);
        chk("st_addr", bus.dmem_addr, 32'h0000_0100);
        chk("st_we", {31'b0, bus.dmem_we}, 32'h1);
        chk("st_done", {31'b0, access_done}, 32'h1);
        idle_cycle(1'b0);
        chk("st_done_once", {31'b0, access_done}, 32'h0);

        // signed upper-half load with three wait cycles, then back-to-back byte load
        run_access(1'b1, 1'b0, 4'b1100, 32'h0000_0202, 32'h0, 1'b1, 32'h8001_1234, 3, st);
        chk("ldh_stall_cnt", st, 32'd5);
        chk("ldh_data", ReadData_M, 32'hFFFF_8001);
        run_access(1'b1, 1'b0, 4'b0001, 32'h0000_0204, 32'h0, 1'b0, 32'h0000_00F0, 0, st);
        chk("ldb_data", ReadData_M, 32'h0000_00F0);

        // more lane patterns
        run_access(1'b0, 1'b1, 4'b0011, 32'h0000_0400, 32'h1234_5678, 1'b0, 32'h0, 1, st);
        chk("sth_wdata", bus.dmem_wdata, 32'h5678_5678);
        run_access(1'b0, 1'b1, 4'b0110, 32'h0000_0401, 32'h1234_5678, 1'b0, 32'h0, 0, st);
        chk("st_odd_wdata", bus.dmem_wdata, 32'h1234_5678);
        run_access(1'b1, 1'b0, 4'b0100, 32'h0000_0502, 32'h0, 1'b1, 32'h0080_0000, 2, st);
        chk("ldb_sext", ReadData_M, 32'hFFFF_FF80);
        run_access(1'b1, 1'b0, 4'b1100, 32'h0000_0602, 32'h0, 1'b0, 32'h8001_1234, 0, st);
        chk("ldh_zext", ReadData_M, 32'h0000_8001);

        // read and write together: the write wins and load data is untouched
        run_access(1'b1, 1'b1, 4'b1111, 32'h0000_0700, 32'hA5A5_0F0F, 1'b0, 32'h1111_1111, 0, st);
        chk("rw_we", {31'b0, bus.dmem_we}, 32'h1);
        chk("rw_rd_held", ReadData_M, 32'h0000_8001);

        // no access: enables zero, then idle cycles with stray acks
        run_access(1'b1, 1'b0, 4'b0000, 32'h0000_0800, 32'h0, 1'b0, 32'h0, 0, st);
        chk("be0_stall", st, 32'd0);
        for (int i = 0; i < 10; i++) idle_cycle(i[0]);
        chk("spur_rd", ReadData_M, 32'h0000_8001);

        // full-word load ignores the sign flag
        run_access(1'b1, 1'b0, 4'b1111, 32'h0000_0010, 32'h0, 1'b1, 32'hCAFE_BABE, 0, st);
        chk("ldw_signed", ReadData_M, 32'hCAFE_BABE);
        run_access(1'b1, 1'b0, 4'b1111, 32'h0000_0010, 32'h0, 1'b0, 32'hCAFE_BABE, 1, st);
        chk("ldw_unsigned", ReadData_M, 32'hCAFE_BABE);
        idle_cycle(1'b0);

        // reset in the second BUSY cycle, ack arrives after the reset edge
        step();
        MemRead_M = 1'b1; MemWrite_M = 1'b0; ByteControl_M = 4'b1111;
        Addr_M = 32'h0000_0300; WriteData_M = 32'h1111_2222; LoadSigned_M = 1'b0;
        exp_stall = 1'b1; exp_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        for (int b = 0; b < 2; b++) begin
            step();
            if (b == 1) rst_n = 1'b0;
            exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h0000_0300; exp_be = 4'b1111;
            exp_wdata = 32'h1111_2222; exp_stall = 1'b1;
        end
        step();
        rst_n = 1'b1; MemRead_M = 1'b0;
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h5555_5555;
        exp_req = 0; exp_we = 0; exp_addr = 0; exp_be = 0; exp_wdata = 0; exp_rd = 0;
        exp_stall = 0; exp_done = 0; exp_err = 0;
        @(negedge clk);
        chk("rst_req", {31'b0, bus.dmem_req}, 32'h0);
        idle_cycle(1'b0);
        chk("rst_no_done", {31'b0, access_done}, 32'h0);
        chk("rst_rd", ReadData_M, 32'h0);

`ifdef MEM_TIMEOUT_EN
        // no ack at all: abort after TO BUSY cycles
        run_access(1'b1, 1'b0, 4'b1111, 32'h0000_0900, 32'h0, 1'b0, 32'h7777_7777, 100, st);
        chk("to_err", {31'b0, bus_err}, 32'h1);
        chk("to_done", {31'b0, access_done}, 32'h1);
        chk("to_rd", ReadData_M, 32'h0);
        chk("to_stall_cnt", st, 32'd5);
        // ack on the last allowed cycle completes normally
        run_access(1'b1, 1'b0, 4'b1111, 32'h0000_0904, 32'h0, 1'b0, 32'h7777_7777, TO - 1, st);
        chk("to_edge_err", {31'b0, bus_err}, 32'h0);
        chk("to_edge_rd", ReadData_M, 32'h7777_7777);
        idle_cycle(1'b0);
`endif

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_access_ctrl.md
Name: mem_stage_access_ctrl

Overview:
- Memory-stage data-access controller. Sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register.
- Takes the registered memory-stage control and data (address = ALU result, store data, byte enables, read/write), runs a req/ack handshake with the data memory, and steers byte lanes for stores and loads.
- Holds the pipeline with stall_M until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255, BUSY cycles without ack before abort (used only with MEM_TIMEOUT_EN).
- TO_CNT_W, 8, width of the timeout counter. Must satisfy 2^TO_CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- MemRead_M  in  1  load in memory stage.
- MemWrite_M  in  1  store in memory stage.
- ByteControl_M  in  4  byte-lane enables from EX/MEM.
- LoadSigned_M  in  1  1 = sign-extend sub-word load, 0 = zero-extend.
- Addr_M  in  32  effective address (ALU result).
- WriteData_M  in  32  store data, right-justified.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address, {Addr_M[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-steered store data.
- dmem_rdata  in  32  read data, valid with dmem_ack.
- dmem_ack  in  1  access complete.
- stall_M  out  1  hold PC/IF/ID/ID-EX/EX-MEM; bubble MEM/WB.
- ReadData_M  out  32  aligned and extended load data.
- access_done  out  1  one-cycle pulse when access retires.
- bus_err  out  1  one-cycle pulse with access_done on timeout abort.

Behaviour:
- access = (MemRead_M | MemWrite_M) & (ByteControl_M != 0). If both read and write are set, write wins.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If access: latch dmem_addr, dmem_be, dmem_we, dmem_wdata; dmem_req<=1; go to BUSY.
  - stall_M = access (combinational) in IDLE.
- BUSY:
  - stall_M = 1; dmem_req is held at 1 and the bus outputs are held stable.
  - On dmem_ack: dmem_req<=0; ReadData_M<=aligned(dmem_rdata) for reads (unchanged for writes); go to DONE.
- DONE:
  - stall_M = 0; access_done = 1; go unconditionally to IDLE, so the same instruction is never re-issued.
- Minimum cost with ack in the first BUSY cycle: 2 stall cycles. Each extra wait cycle adds 1.
- Store lane steering:
  - be 0001/0010/0100/1000 → {4{WD[7:0]}}.
  - be 0011/1100 → {2{WD[15:0]}}.
  - All other patterns → WD unchanged.
- Load alignment:
  - Single-byte be: select lane k and shift to [7:0].
  - 0011/1100: select the half and shift to [15:0].
  - Extend per LoadSigned_M.
  - Other patterns: raw word.
- ReadData_M holds its value until the next completed read.
- dmem_ack outside BUSY is ignored.
- Reset (rst_n=0 at an edge):
  - state=IDLE, counter=0.
  - dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ReadData_M, access_done, bus_err all 0.
  - stall_M follows the IDLE rule.
  - Reset during BUSY drops dmem_req at that edge; a late ack is ignored.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - The counter increments each BUSY cycle without ack.
  - When counter == TIMEOUT_CYCLES-1 and there is no ack: dmem_req<=0; ReadData_M<=32'h0 for reads; go to DONE with bus_err=1 for that cycle.
  - Counter clears on entry to BUSY.
  - Ack on the timeout cycle wins (normal completion, no bus_err).
- Undefined: BUSY waits indefinitely; no counter logic; bus_err tied 0.

Test Plan:
- Store Addr=0x103, be=1000, WD=0x000000AB, ack 1 cycle after req → dmem_addr=0x100, be=1000, wdata=0xABABABAB, we=1; stall_M high 2 cycles; access_done pulses once.
- Load Addr=0x202, be=1100, LoadSigned=1, rdata=0x8001_1234, ack after 3 wait cycles → ReadData_M=0xFFFF8001; stall 5 cycles; then back-to-back load be=0001, signed=0, rdata=0x000000F0 → ReadData_M=0x000000F0.
- MemRead=MemWrite=0 for 10 cycles with spurious dmem_ack pulses → dmem_req never asserts, stall_M=0, ReadData_M unchanged.
- rst_n=0 in 2nd BUSY cycle, ack arrives next cycle → dmem_req=0 after reset edge, all outputs 0, ack ignored, no access_done.
- MEM_TIMEOUT_EN defined with TIMEOUT_CYCLES=4, no ack → req drops after 4 BUSY cycles; access_done=bus_err=1 for one cycle; ReadData_M=0. Rerun with ack on 4th cycle → bus_err=0, data captured.
- Load be=1111 Addr=0x10, rdata=0xCAFEBABE → ReadData_M=0xCAFEBABE regardless of LoadSigned.
